// File: rtl/avmm_check_pkg.sv
// Shared definitions for the Avalon-MM memory check master: FSM encoding,
// operation mode codes and the word-index width.
package avmm_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_READ   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam logic [1:0] MODE_NONE  = 2'b00;
    localparam logic [1:0] MODE_FILL  = 2'b01;
    localparam logic [1:0] MODE_CHECK = 2'b10;
    localparam logic [1:0] MODE_BOTH  = 2'b11;

    localparam int IDX_W = 16;

endpackage

// File: rtl/avmm_pattern_gen.sv
// Pattern and address for word index i: seed + i and base + i, both wrapping
// at their own width. Used once for issued commands, once for returned data.
module avmm_pattern_gen
    import avmm_check_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DATA_W-1:0] seed,
    input  logic [IDX_W-1:0]  index,
    output logic [DATA_W-1:0] pattern,
    output logic [ADDR_W-1:0] addr
);

    assign pattern = seed + DATA_W'(index);
    assign addr    = base_addr + ADDR_W'(index);

endmodule

// File: rtl/avmm_mem_check_master.sv
// Avalon-MM master that fills a word range with seed+i and/or reads it back
// with pipelined reads, counting mismatches and remembering the first one.
module avmm_mem_check_master
    import avmm_check_pkg::*;
#(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 32,
    parameter int MAX_PEND = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [15:0]           word_count,
    input  logic [DATA_W-1:0]     seed,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           err_count,
    output logic [ADDR_W-1:0]     err_addr,
    output logic [ADDR_W-1:0]     avm_address,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    input  logic [DATA_W-1:0]     avm_readdata,
    input  logic                  avm_readdatavalid,
    input  logic                  avm_waitrequest
);

    localparam logic [3:0] MAX_PEND_C = 4'(MAX_PEND);

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          mode_q;
    logic [ADDR_W-1:0]   base_q;
    logic [15:0]         count_q;
    logic [DATA_W-1:0]   seed_q;
    logic [IDX_W-1:0]    issue_idx;
    logic [IDX_W-1:0]    ret_idx;
    logic [3:0]          pend;
    logic [DATA_W-1:0]   ret_pattern;
    logic [ADDR_W-1:0]   ret_addr;
    logic                start_acc;
    logic                wr_acc;
    logic                rd_acc;
    logic                rdv_ok;
    logic                last_issue;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    avmm_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_issue_gen (
        .base_addr (base_q),
        .seed      (seed_q),
        .index     (issue_idx),
        .pattern   (avm_writedata),
        .addr      (avm_address)
    );

    avmm_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_return_gen (
        .base_addr (base_q),
        .seed      (seed_q),
        .index     (ret_idx),
        .pattern   (ret_pattern),
        .addr      (ret_addr)
    );

    assign avm_byteenable = '1;
    assign busy           = (state != ST_IDLE);
    assign avm_write      = (state == ST_WRITE);
    // Reads are throttled by the outstanding count; a stalled read stays up
    // because pend can only fall while no read is being accepted.
    assign avm_read       = (state == ST_READ) && (pend < MAX_PEND_C);

    assign start_acc  = (state == ST_IDLE) && start;
    assign wr_acc     = avm_write && !avm_waitrequest;
    assign rd_acc     = avm_read && !avm_waitrequest;
    assign rdv_ok     = avm_readdatavalid && (pend != 4'd0);
    assign last_issue = (issue_idx == count_q - 16'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (mode == MODE_NONE || word_count == 16'd0) begin
                        state_nxt = ST_FINISH;
                    end else if (mode[0]) begin
                        state_nxt = ST_WRITE;
                    end else begin
                        state_nxt = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                if (wr_acc && last_issue) begin
                    state_nxt = mode_q[1] ? ST_READ : ST_FINISH;
                end
            end
            ST_READ: begin
                if (rd_acc && last_issue) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pend == 4'd0) begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q    <= MODE_NONE;
            base_q    <= '0;
            count_q   <= '0;
            seed_q    <= '0;
            issue_idx <= '0;
            ret_idx   <= '0;
            err_count <= '0;
            err_addr  <= '0;
        end else if (start_acc) begin
            mode_q    <= mode;
            base_q    <= base_addr;
            count_q   <= word_count;
            seed_q    <= seed;
            issue_idx <= '0;
            ret_idx   <= '0;
            err_count <= '0;
            err_addr  <= '0;
        end else begin
            // Index restarts after the last write so a fill-then-check pass
            // reads from the first word again.
            if (wr_acc || rd_acc) begin
                issue_idx <= last_issue ? '0 : issue_idx + 1'b1;
            end
            if (rdv_ok) begin
                ret_idx <= ret_idx + 1'b1;
                if (avm_readdata != ret_pattern) begin
                    err_count <= sat_inc(err_count);
                    if (err_count == 16'd0) begin
                        err_addr <= ret_addr;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend <= '0;
        end else begin
            case ({rd_acc, rdv_ok})
                2'b10:   pend <= pend + 4'd1;
                2'b01:   pend <= pend - 4'd1;
                default: pend <= pend;
            endcase
        end
    end

    // Registered so the pulse lands in the cycle after FINISH, with busy low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done <= 1'b0;
        end else begin
            done <= (state == ST_FINISH);
        end
    end

endmodule
